qspi_seq_ctrl: RTL and testbench

- Master-side sequencer that drives one QSPI flash/peripheral transaction: command, address, dummy and data phases, in single-line or quad mode.
- Sits between the register/uDMA front end, which supplies the transaction descriptor and data words, and the QSPI pads (clk, csn0-3, sdo/oe/sdi 0-3).
- Generates SCLK from the system clock.
- Produces an end-of-transfer interrupt.

---
 rtl/qspi_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_qspi_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_seq_ctrl.sv
// QSPI master sequencer: one cmd/addr/dummy/data transaction per start pulse, SPI mode 0,
// single or quad lines, SCLK half-period timed by a down-counter on clk_i.
//
// state     | meaning
// IDLE      | waiting for start_i; descriptor latched on start
// CSN_SETUP | chip select low for one half-period before the first SCLK
// CMD       | command bits
// ADDR      | address bits
// DUMMY     | dummy SCLK cycles
// WDATA     | write data, words pulled with tx_valid_i/tx_ready_o
// RDATA     | read data, words pushed with rx_valid_o
// CSN_HOLD  | chip select low for one half-period after the last falling edge
// EOT       | chip select high, end-of-transfer pulse
module qspi_seq_ctrl #(
    parameter int DIV_W = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             rw_i,
    input  logic             quad_i,
    input  logic [1:0]       csn_sel_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic [31:0]      cmd_i,
    input  logic [5:0]       cmd_len_i,
    input  logic [31:0]      addr_i,
    input  logic [5:0]       addr_len_i,
    input  logic [7:0]       dummy_i,
    input  logic [LEN_W-1:0] data_len_i,
    input  logic [31:0]      tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [31:0]      rx_data_o,
    output logic             rx_valid_o,
    output logic             busy_o,
    output logic             eot_o,
    output logic             spi_clk_o,
    output logic             spi_csn0_o,
    output logic             spi_csn1_o,
    output logic             spi_csn2_o,
    output logic             spi_csn3_o,
    output logic             spi_sdo0_o,
    output logic             spi_sdo1_o,
    output logic             spi_sdo2_o,
    output logic             spi_sdo3_o,
    output logic             spi_oe0_o,
    output logic             spi_oe1_o,
    output logic             spi_oe2_o,
    output logic             spi_oe3_o,
    input  logic             spi_sdi0_i,
    input  logic             spi_sdi1_i,
    input  logic             spi_sdi2_i,
    input  logic             spi_sdi3_i
);
    typedef enum logic [3:0] {
        IDLE, CSN_SETUP, CMD, ADDR, DUMMY, WDATA, RDATA, CSN_HOLD, EOT
    } state_t;

    state_t           state, state_nxt;
    state_t           after_setup, after_cmd, after_addr, after_dummy;
    logic             rw_q, quad_q, need_word, sclk;
    logic [1:0]       csn_sel_q;
    logic [DIV_W-1:0] div_q, div_cnt;
    logic [31:0]      cmd_q, addr_q, tx_sh, rx_sh, rx_nxt, word_mask;
    logic [5:0]       cmd_len_q, addr_len_q, cmd_len_c, addr_len_c, word_bits, step6;
    logic [7:0]       dummy_q;
    logic [LEN_W-1:0] data_len_q, len_left, step;
    logic             tick, run, in_phase, rise, fall, last, csn_act;
    logic [3:0]       sdo, oe;

    assign cmd_len_c  = (cmd_len_i  > 6'd32) ? 6'd32 : cmd_len_i;
    assign addr_len_c = (addr_len_i > 6'd32) ? 6'd32 : addr_len_i;

    assign in_phase = (state == CMD) || (state == ADDR) || (state == DUMMY) ||
                      (state == WDATA) || (state == RDATA);
    assign tick  = (div_cnt == '0);
    assign run   = !((state == WDATA) && need_word);
    assign rise  = in_phase && tick && run && !sclk;
    assign fall  = in_phase && tick && run && sclk;
    assign step6 = (quad_q && (state != DUMMY)) ? 6'd4 : 6'd1;
    assign step  = LEN_W'(step6);
    assign last  = (len_left <= step);
    assign rx_nxt = quad_q ? {rx_sh[27:0], spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i}
                           : {rx_sh[30:0], spi_sdi1_i};
    // Bits past the end of a short final word go out as zeros.
    assign word_mask = (len_left >= LEN_W'(32)) ? 32'hFFFF_FFFF
                                                : ~(32'hFFFF_FFFF >> len_left[5:0]);

    assign after_dummy = (data_len_q != '0) ? (rw_q ? RDATA : WDATA) : CSN_HOLD;
    assign after_addr  = (dummy_q    != '0) ? DUMMY : after_dummy;
    assign after_cmd   = (addr_len_q != '0) ? ADDR  : after_addr;
    assign after_setup = (cmd_len_q  != '0) ? CMD   : after_cmd;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_i) state_nxt = CSN_SETUP;
            CSN_SETUP: if (tick) state_nxt = after_setup;
            CMD:       if (fall && last) state_nxt = after_cmd;
            ADDR:      if (fall && last) state_nxt = after_addr;
            DUMMY:     if (fall && last) state_nxt = after_dummy;
            WDATA,
            RDATA:     if (fall && last) state_nxt = CSN_HOLD;
            CSN_HOLD:  if (tick) state_nxt = EOT;
            EOT:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        csn_act    = 1'b0;
        oe         = 4'h0;
        sdo        = 4'h0;
        busy_o     = (state != IDLE) && (state != EOT);
        eot_o      = (state == EOT);
        tx_ready_o = (state == WDATA) && need_word && tx_valid_i;
        case (state)
            CSN_SETUP, CSN_HOLD: csn_act = 1'b1;
            CMD, ADDR, WDATA: begin
                csn_act = 1'b1;
                if (quad_q) begin
                    oe  = 4'hF;
                    sdo = tx_sh[31:28];
                end else begin
                    oe  = 4'h1;
                    sdo = {3'b000, tx_sh[31]};
                end
            end
            DUMMY, RDATA: begin
                csn_act = 1'b1;
                oe      = quad_q ? 4'h0 : 4'h1;
            end
            default: ;
        endcase
    end

    assign spi_clk_o  = sclk;
    assign spi_csn0_o = !(csn_act && (csn_sel_q == 2'd0));
    assign spi_csn1_o = !(csn_act && (csn_sel_q == 2'd1));
    assign spi_csn2_o = !(csn_act && (csn_sel_q == 2'd2));
    assign spi_csn3_o = !(csn_act && (csn_sel_q == 2'd3));
    assign {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o} = sdo;
    assign {spi_oe3_o, spi_oe2_o, spi_oe1_o, spi_oe0_o}     = oe;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rw_q <= 1'b0; quad_q <= 1'b0; csn_sel_q <= '0; div_q <= '0; div_cnt <= '0;
            cmd_q <= '0; addr_q <= '0; cmd_len_q <= '0; addr_len_q <= '0; dummy_q <= '0;
            data_len_q <= '0; len_left <= '0; tx_sh <= '0; rx_sh <= '0; word_bits <= '0;
            need_word <= 1'b0; sclk <= 1'b0; rx_data_o <= '0; rx_valid_o <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (!tick)                  div_cnt <= div_cnt - DIV_W'(1);
            else if (run || tx_ready_o) div_cnt <= div_q;
            if (rise || fall) sclk <= !sclk;

            if (state == IDLE && start_i) begin
                rw_q       <= rw_i;
                quad_q     <= quad_i;
                csn_sel_q  <= csn_sel_i;
                div_q      <= clk_div_i;
                div_cnt    <= clk_div_i;
                cmd_len_q  <= cmd_len_c;
                addr_len_q <= addr_len_c;
                cmd_q      <= cmd_i  & ~(32'hFFFF_FFFF >> cmd_len_c);
                addr_q     <= addr_i & ~(32'hFFFF_FFFF >> addr_len_c);
                dummy_q    <= dummy_i;
                data_len_q <= data_len_i;
            end

            if (state_nxt != state) begin
                case (state_nxt)
                    CMD:   begin tx_sh <= cmd_q;  len_left <= LEN_W'(cmd_len_q);  end
                    ADDR:  begin tx_sh <= addr_q; len_left <= LEN_W'(addr_len_q); end
                    DUMMY: begin tx_sh <= '0;     len_left <= LEN_W'(dummy_q);    end
                    WDATA: begin
                        tx_sh <= '0; len_left <= data_len_q; need_word <= 1'b1; word_bits <= '0;
                    end
                    RDATA: begin rx_sh <= '0; len_left <= data_len_q; word_bits <= '0; end
                    default: ;
                endcase
            end else begin
                if (fall) begin
                    tx_sh    <= tx_sh << step6;
                    len_left <= len_left - step;
                    if (state == WDATA) begin
                        if (word_bits + step6 == 6'd32) begin
                            need_word <= 1'b1;
                            word_bits <= '0;
                        end else begin
                            word_bits <= word_bits + step6;
                        end
                    end
                end
                if (rise && state == RDATA) begin
                    if ((word_bits + step6 == 6'd32) || last) begin
                        rx_data_o  <= rx_nxt;
                        rx_valid_o <= 1'b1;
                        rx_sh      <= '0;
                        word_bits  <= '0;
                    end else begin
                        rx_sh     <= rx_nxt;
                        word_bits <= word_bits + step6;
                    end
                end
                if (tx_ready_o) begin
                    tx_sh     <= tx_data_i & word_mask;
                    need_word <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_qspi_seq_ctrl.sv
// Directed bench for qspi_seq_ctrl: a linear run of transactions, a clock-synchronous
// pad monitor, a quad read slave and a tx word feeder.
`timescale 1ns/1ps
module tb_qspi_seq_ctrl;
    localparam int DIV_W = 8;
    localparam int LEN_W = 16;

    logic             clk_i = 1'b0, rstn_i = 1'b0, start_i = 1'b0, rw_i = 1'b0, quad_i = 1'b0;
    logic [1:0]       csn_sel_i = '0;
    logic [DIV_W-1:0] clk_div_i = '0;
    logic [31:0]      cmd_i = '0, addr_i = '0, tx_data_i;
    logic [5:0]       cmd_len_i = '0, addr_len_i = '0;
    logic [7:0]       dummy_i = '0;
    logic [LEN_W-1:0] data_len_i = '0;
    logic             tx_valid_i = 1'b0, tx_ready_o, rx_valid_o, busy_o, eot_o, spi_clk_o;
    logic [31:0]      rx_data_o;
    logic spi_csn0_o, spi_csn1_o, spi_csn2_o, spi_csn3_o;
    logic spi_sdo0_o, spi_sdo1_o, spi_sdo2_o, spi_sdo3_o;
    logic spi_oe0_o, spi_oe1_o, spi_oe2_o, spi_oe3_o;
    logic [3:0] sdi;

    qspi_seq_ctrl #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .rw_i(rw_i), .quad_i(quad_i),
        .csn_sel_i(csn_sel_i), .clk_div_i(clk_div_i), .cmd_i(cmd_i), .cmd_len_i(cmd_len_i),
        .addr_i(addr_i), .addr_len_i(addr_len_i), .dummy_i(dummy_i), .data_len_i(data_len_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o), .eot_o(eot_o),
        .spi_clk_o(spi_clk_o),
        .spi_csn0_o(spi_csn0_o), .spi_csn1_o(spi_csn1_o), .spi_csn2_o(spi_csn2_o), .spi_csn3_o(spi_csn3_o),
        .spi_sdo0_o(spi_sdo0_o), .spi_sdo1_o(spi_sdo1_o), .spi_sdo2_o(spi_sdo2_o), .spi_sdo3_o(spi_sdo3_o),
        .spi_oe0_o(spi_oe0_o), .spi_oe1_o(spi_oe1_o), .spi_oe2_o(spi_oe2_o), .spi_oe3_o(spi_oe3_o),
        .spi_sdi0_i(sdi[0]), .spi_sdi1_i(sdi[1]), .spi_sdi2_i(sdi[2]), .spi_sdi3_i(sdi[3])
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0, miscompares = 0;

    int rise_cnt = 0, eot_cnt = 0, busy_cyc = 0, rdy_cnt = 0, rx_cnt = 0;
    int csn_low [4] = '{0, 0, 0, 0};
    logic [3:0]  sdo_log [0:511];
    logic [3:0]  oe_log  [0:511];
    logic [31:0] rx_log  [0:15];
    logic        prev_sclk = 1'b0;

    logic [31:0] tx_words [0:3] = '{default: '0};
    int          tx_idx = 0, tx_base = 0;
    logic [63:0] rd_bits = '0;
    int          rd_base = 100000;

    assign tx_data_i = tx_words[2'(tx_idx - tx_base)];

    always @(posedge clk_i) if (tx_ready_o) tx_idx <= tx_idx + 1;

    // Quad slave: nibble k of rd_bits is on sdi while the DUT takes its k-th data sample.
    always_comb begin
        int idx;
        idx = rise_cnt - rd_base;
        sdi = 4'h0;
        if (idx >= 0 && idx < 16) sdi = rd_bits[63 - 4*idx -: 4];
    end

    always @(negedge clk_i) begin
        if (spi_clk_o && !prev_sclk) begin
            sdo_log[rise_cnt] = {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o};
            oe_log[rise_cnt]  = {spi_oe3_o, spi_oe2_o, spi_oe1_o, spi_oe0_o};
            rise_cnt = rise_cnt + 1;
        end
        prev_sclk = spi_clk_o;
        if (eot_o)      eot_cnt  = eot_cnt + 1;
        if (busy_o)     busy_cyc = busy_cyc + 1;
        if (tx_ready_o) rdy_cnt  = rdy_cnt + 1;
        if (rx_valid_o) begin
            rx_log[rx_cnt] = rx_data_o;
            rx_cnt = rx_cnt + 1;
        end
        if (!spi_csn0_o) csn_low[0] = csn_low[0] + 1;
        if (!spi_csn1_o) csn_low[1] = csn_low[1] + 1;
        if (!spi_csn2_o) csn_low[2] = csn_low[2] + 1;
        if (!spi_csn3_o) csn_low[3] = csn_low[3] + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic wait_eot(input string tag, input int e0, input int budget);
        int n = 0;
        while (eot_cnt == e0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        chk(tag, 64'(eot_cnt != e0), 64'd1);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic set_desc(input logic rw, input logic quad, input logic [1:0] sel,
                            input logic [7:0] div, input logic [31:0] cmd, input logic [5:0] cl,
                            input logic [31:0] addr, input logic [5:0] al, input logic [7:0] dm,
                            input logic [15:0] dl);
        rw_i = rw; quad_i = quad; csn_sel_i = sel; clk_div_i = div;
        cmd_i = cmd; cmd_len_i = cl; addr_i = addr; addr_len_i = al; dummy_i = dm; data_len_i = dl;
    endtask

    function automatic logic [31:0] nib_word(input int b);
        logic [31:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[27:0], sdo_log[b + i]};
        return w;
    endfunction

    function automatic logic [7:0] bit_byte(input int b);
        logic [7:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[6:0], sdo_log[b + i][0]};
        return w;
    endfunction

    initial begin
        int r0, e0, b0, c0, c1, c3, t0, x0, n;

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_csn", {spi_csn3_o, spi_csn2_o, spi_csn1_o, spi_csn0_o}, 4'hF);
        chk("rst_pads", {spi_clk_o, spi_oe3_o, spi_oe2_o, spi_oe1_o, spi_oe0_o,
                         spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o}, 9'h000);
        chk("rst_ctl", {busy_o, eot_o, tx_ready_o, rx_valid_o, rx_data_o}, 36'h0);
        rstn_i = 1'b1;

        // Single-line write of command 0x06 only, clk_div=1
        set_desc(1'b0, 1'b0, 2'd0, 8'd1, 32'h0600_0000, 6'd8, 32'h0, 6'd0, 8'd0, 16'd0);
        r0 = rise_cnt; e0 = eot_cnt; b0 = busy_cyc; c0 = csn_low[0]; c1 = csn_low[1];
        pulse_start();
        wait_eot("t1_eot_seen", e0, 200);
        chk("t1_sclks", rise_cnt - r0, 8);
        chk("t1_sdo0", bit_byte(r0), 8'h06);
        chk("t1_oe", oe_log[r0], 4'h1);
        chk("t1_eot_pulses", eot_cnt - e0, 1);
        chk("t1_busy_cycles", busy_cyc - b0, 36);
        chk("t1_csn0_low", csn_low[0] - c0, 36);
        chk("t1_csn1_low", csn_low[1] - c1, 0);

        // Quad read: EB cmd, 24-bit addr, 4 dummy, 64 data bits
        set_desc(1'b1, 1'b1, 2'd0, 8'd0, 32'hEB00_0000, 6'd8, 32'h0012_3400, 6'd24, 8'd4, 16'd64);
        r0 = rise_cnt; e0 = eot_cnt; x0 = rx_cnt;
        rd_bits = 64'hDEAD_BEEF_0123_4567;
        rd_base = r0 + 12;
        pulse_start();
        wait_eot("t2_eot_seen", e0, 200);
        chk("t2_sclks", rise_cnt - r0, 28);
        chk("t2_cmd_addr", nib_word(r0), 32'hEB00_1234);
        chk("t2_oe_addr", oe_log[r0 + 7], 4'hF);
        chk("t2_oe_dummy", oe_log[r0 + 8], 4'h0);
        chk("t2_oe_rdata", oe_log[r0 + 20], 4'h0);
        chk("t2_rx_words", rx_cnt - x0, 2);
        chk("t2_rx0", rx_log[x0], 32'hDEAD_BEEF);
        chk("t2_rx1", rx_log[x0 + 1], 32'h0123_4567);
        rd_base = 100000;

        // Quad write of 40 data bits, second word partial
        set_desc(1'b0, 1'b1, 2'd0, 8'd1, 32'h0, 6'd0, 32'h0, 6'd0, 8'd0, 16'd40);
        tx_base = tx_idx; tx_words[0] = 32'hA5A5_A5A5; tx_words[1] = 32'hFF00_0000;
        tx_valid_i = 1'b1;
        r0 = rise_cnt; e0 = eot_cnt; t0 = rdy_cnt;
        pulse_start();
        wait_eot("t3_eot_seen", e0, 200);
        chk("t3_sclks", rise_cnt - r0, 10);
        chk("t3_word0", nib_word(r0), 32'hA5A5_A5A5);
        chk("t3_tail", {sdo_log[r0 + 8], sdo_log[r0 + 9]}, 8'hFF);
        chk("t3_oe", oe_log[r0 + 9], 4'hF);
        chk("t3_tx_ready", rdy_cnt - t0, 2);

        // Quad write with tx_valid_i withheld at the second word
        set_desc(1'b0, 1'b1, 2'd0, 8'd1, 32'h0, 6'd0, 32'h0, 6'd0, 8'd0, 16'd64);
        tx_base = tx_idx; tx_words[0] = 32'h1234_5678; tx_words[1] = 32'h9ABC_DEF0;
        r0 = rise_cnt; e0 = eot_cnt; t0 = rdy_cnt;
        pulse_start();
        n = 0;
        while (tx_idx == tx_base && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        #1 tx_valid_i = 1'b0;
        chk("t4_first_word", 64'(tx_idx - tx_base), 64'd1);
        repeat (52) @(posedge clk_i);
        #1;
        chk("t4_stall_sclks", rise_cnt - r0, 8);
        chk("t4_stall_pins", {spi_clk_o, spi_csn0_o, busy_o}, 3'b001);
        tx_valid_i = 1'b1;
        wait_eot("t4_eot_seen", e0, 200);
        chk("t4_sclks", rise_cnt - r0, 16);
        chk("t4_word0", nib_word(r0), 32'h1234_5678);
        chk("t4_word1", nib_word(r0 + 8), 32'h9ABC_DEF0);
        chk("t4_tx_ready", rdy_cnt - t0, 2);

        // Reset during the address phase, then a clean transaction
        set_desc(1'b0, 1'b0, 2'd0, 8'd1, 32'h0300_0000, 6'd8, 32'h00AB_CD00, 6'd24, 8'd0, 16'd0);
        e0 = eot_cnt;
        pulse_start();
        repeat (60) @(posedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        chk("t5_rst_csn", {spi_csn3_o, spi_csn2_o, spi_csn1_o, spi_csn0_o}, 4'hF);
        chk("t5_rst_pins", {busy_o, spi_clk_o, spi_oe3_o, spi_oe2_o, spi_oe1_o, spi_oe0_o}, 6'h00);
        repeat (5) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        chk("t5_no_eot", eot_cnt - e0, 0);
        set_desc(1'b0, 1'b0, 2'd0, 8'd1, 32'h9F00_0000, 6'd8, 32'h0, 6'd0, 8'd0, 16'd0);
        r0 = rise_cnt; e0 = eot_cnt;
        pulse_start();
        wait_eot("t5_eot_seen", e0, 200);
        chk("t5_sdo0", bit_byte(r0), 8'h9F);
        chk("t5_sclks", rise_cnt - r0, 8);

        // csn_sel=3 with a second start while busy
        set_desc(1'b0, 1'b0, 2'd3, 8'd0, 32'hA500_0000, 6'd8, 32'h0, 6'd0, 8'd0, 16'd0);
        r0 = rise_cnt; e0 = eot_cnt; b0 = busy_cyc;
        c0 = csn_low[0]; c1 = csn_low[1]; c3 = csn_low[3];
        pulse_start();
        repeat (4) @(posedge clk_i);
        #1 csn_sel_i = 2'd1;
        pulse_start();
        wait_eot("t6_eot_seen", e0, 200);
        repeat (40) @(posedge clk_i);
        #1;
        chk("t6_eot_pulses", eot_cnt - e0, 1);
        chk("t6_csn3_low", csn_low[3] - c3, 18);
        chk("t6_csn1_low", csn_low[1] - c1, 0);
        chk("t6_csn0_low", csn_low[0] - c0, 0);
        chk("t6_busy_cycles", busy_cyc - b0, 18);
        chk("t6_sdo0", bit_byte(r0), 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
